// File: rtl/uart8_pkg.sv
// Shared state type, oversampling default and mid-bit sample positions for the UART receiver.
package uart8_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;

  localparam int OVERSAMPLE_DEF = 16;

  // 1-based tick positions within a bit at which the line is sampled
  localparam int MID_LO = 7;
  localparam int MID    = 8;
  localparam int MID_HI = 9;

  function automatic int divRound(input int clkRate, input int baudRate, input int ovs);
    int den;
    den = baudRate * ovs;
    return (clkRate + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart8_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, restartable from 0.
module uart8_baud_tick import uart8_pkg::*; #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int DIV = divRound(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      cnt <= '0;
    else if (restart || cnt == LAST) cnt <= '0;
    else                             cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart8_rx16.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
module uart8_rx16 import uart8_pkg::*; #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int PW = TW + 1;
  localparam logic [PW-1:0] POS_END = PW'(OVERSAMPLE);
  localparam logic [PW-1:0] POS_LO  = PW'(MID_LO);
  localparam logic [PW-1:0] POS_MID = PW'(MID);
  localparam logic [PW-1:0] POS_HI  = PW'(MID_HI);

  logic rxMeta, rxSync, rxPrev;
  logic [1:0] flushCnt;
  logic armed;

  // armed only after the synchronizer holds real line data and the line has been seen high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta   <= 1'b1;
      rxSync   <= 1'b1;
      rxPrev   <= 1'b1;
      flushCnt <= '0;
      armed    <= 1'b0;
    end else begin
      rxMeta <= rxIn;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      if (flushCnt != 2'd2) flushCnt <= flushCnt + 2'd1;
      armed <= armed | ((flushCnt == 2'd2) && rxSync);
    end
  end

  logic tick, restart;

  uart8_baud_tick #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) uBaud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  rxState_t      state, stateN;
  logic [TW-1:0] tickCnt, tickN;
  logic [2:0]    bitCnt, bitN;
  logic          s7, s7N, s8, s8N;
  logic [7:0]    shReg, shN, outN;
  logic          doneN, errN;
  logic [PW-1:0] pos;
  logic          at7, at8, at9, decide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tickCnt <= '0;
      bitCnt  <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      shReg   <= '0;
      rxOut   <= '0;
      rxDone  <= 1'b0;
      rxErr   <= 1'b0;
    end else begin
      state   <= stateN;
      tickCnt <= tickN;
      bitCnt  <= bitN;
      s7      <= s7N;
      s8      <= s8N;
      shReg   <= shN;
      rxOut   <= outN;
      rxDone  <= doneN;
      rxErr   <= errN;
    end
  end

  // Majority early-out: if samples 7 and 8 agree the vote is settled at tick 8,
  // otherwise sample 9 breaks the tie. Either way the winning value is rxSync.
  always_comb begin
    stateN  = state;
    tickN   = tickCnt;
    bitN    = bitCnt;
    s7N     = s7;
    s8N     = s8;
    shN     = shReg;
    outN    = rxOut;
    doneN   = 1'b0;
    errN    = 1'b0;
    restart = 1'b0;

    pos    = {1'b0, tickCnt} + PW'(1);
    at7    = tick && (pos == POS_LO);
    at8    = tick && (pos == POS_MID);
    at9    = tick && (pos == POS_HI) && (s7 != s8);
    decide = (at8 && (s7 == rxSync)) || at9;

    if ((state inside {START, DATA, STOP}) && tick) begin
      tickN = (pos == POS_END) ? '0 : pos[TW-1:0];
      if (at7) s7N = rxSync;
      if (at8) s8N = rxSync;
    end

    unique case (state)
      IDLE: begin
        tickN = '0;
        bitN  = '0;
        if (rxEn && armed && rxPrev && !rxSync) begin
          stateN  = START;
          restart = 1'b1;
        end
      end
      START: if (decide) stateN = rxSync ? IDLE : DATA;
      DATA: if (decide) begin
        shN  = {rxSync, shReg[7:1]};
        bitN = bitCnt + 3'd1;
        if (bitCnt == 3'd7) stateN = STOP;
      end
      STOP: if (decide) begin
        if (rxSync) begin
          stateN = IDLE;
          outN   = shReg;
          doneN  = 1'b1;
        end else begin
          stateN = BREAK;
          errN   = 1'b1;
          tickN  = '0;
        end
      end
      BREAK: if (tick) begin
        if (!rxSync)              tickN  = '0;
        else if (pos == POS_END)  stateN = IDLE;
        else                      tickN  = pos[TW-1:0];
      end
      default: stateN = IDLE;
    endcase

    if (!rxEn) begin
      stateN = IDLE;
      tickN  = '0;
      bitN   = '0;
      shN    = shReg;
      outN   = rxOut;
      doneN  = 1'b0;
      errN   = 1'b0;
    end
  end

  assign rxBusy = (state != IDLE);

endmodule

// File: tb/tb_uart8_rx16.sv
// Self-checking bench for uart8_rx16 at a scaled clock (round(1.2e6/153600) = 8 clocks per tick).
module tb_uart8_rx16;
  localparam int TICK   = 8;            // clocks per oversample tick
  localparam int BIT    = TICK * 16;    // 128 clocks per bit
  localparam int GLITCH = 20;           // ~2.5 ticks, same ratio as 200 clocks at defaults
  localparam int LAT_LO = BIT * 19 / 2 - TICK + 3;
  localparam int LAT_HI = BIT * 19 / 2 + TICK + 3;

  logic       clk = 1'b0;
  logic       reset, rxEn, rxIn;
  logic       rxBusy, rxDone, rxErr;
  logic [7:0] rxOut;

  uart8_rx16 #(.CLOCK_RATE(1200000), .BAUD_RATE(9600), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(rxIn),
    .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, startCyc = 0, doneCyc = 0;
  int doneCnt = 0, errCnt = 0, bothCnt = 0, busyCyc = 0;
  logic [7:0] gotQ[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxDone) begin
      doneCnt++;
      gotQ.push_back(rxOut);
      doneCyc = cyc;
    end
    if (rxErr) errCnt++;
    if (rxDone && rxErr) bothCnt++;
    if (rxBusy) busyCyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // start bit plus data bits 0..n-1, LSB first
  task automatic sendBits(input logic [7:0] b, input int n, input int bitClk);
    logic [8:0] fr;
    fr = {b, 1'b0};
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      rxIn = fr[i];
      if (i == 0) startCyc = cyc;
      repeat (bitClk - 1) @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int bitClk);
    sendBits(b, 8, bitClk);
    @(negedge clk);
    rxIn = stopBit;
    repeat (bitClk - 1) @(negedge clk);
    @(negedge clk);
    rxIn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int d0, e0, b0, q0, lat, bc, gap;
  logic [7:0] rb;

  initial begin
    reset = 1'b0; rxEn = 1'b1; rxIn = 1'b1;
    idle(5);
    chk("rst_busy", 32'(rxBusy), 0);
    chk("rst_done", 32'(rxDone), 0);
    chk("rst_err",  32'(rxErr),  0);
    chk("rst_out",  32'(rxOut),  0);
    reset = 1'b1;
    idle(20);

    // single good frame and its latency
    d0 = doneCnt; e0 = errCnt;
    sendFrame(8'h45, 1'b1, BIT);
    idle(BIT);
    lat = doneCyc - startCyc;
    chk("f45_done", 32'(doneCnt - d0), 1);
    chk("f45_out",  32'(rxOut), 'h45);
    chk("f45_err",  32'(errCnt - e0), 0);
    chk("f45_lat",  32'(lat >= LAT_LO && lat <= LAT_HI), 1);

    // short glitch on idle line
    d0 = doneCnt; e0 = errCnt; b0 = busyCyc;
    @(negedge clk); rxIn = 1'b0;
    idle(GLITCH);
    rxIn = 1'b1;
    idle(BIT * 2);
    chk("gl_busy",  32'((busyCyc - b0) > 0 && (busyCyc - b0) <= 8 * TICK + 3), 1);
    chk("gl_done",  32'(doneCnt - d0), 0);
    chk("gl_err",   32'(errCnt - e0), 0);
    chk("gl_idle",  32'(rxBusy), 0);

    // framing error, break recovery, next frame
    d0 = doneCnt; e0 = errCnt;
    sendFrame(8'hA5, 1'b0, BIT);
    chk("fe_brk_busy", 32'(rxBusy), 1);
    idle(BIT * 2);
    chk("fe_err",   32'(errCnt - e0), 1);
    chk("fe_done",  32'(doneCnt - d0), 0);
    chk("fe_keep",  32'(rxOut), 'h45);
    chk("fe_idle",  32'(rxBusy), 0);
    sendFrame(8'h3C, 1'b1, BIT);
    idle(BIT);
    chk("fe_next_done", 32'(doneCnt - d0), 1);
    chk("fe_next_out",  32'(rxOut), 'h3C);

    // reset during bit 4 of 0xFF
    d0 = doneCnt; e0 = errCnt;
    sendBits(8'hFF, 4, BIT);
    @(negedge clk); rxIn = 1'b1;
    idle(BIT / 2);
    chk("mr_busy_pre", 32'(rxBusy), 1);
    reset = 1'b0;
    #1;
    chk("mr_busy", 32'(rxBusy), 0);
    chk("mr_done", 32'(rxDone), 0);
    chk("mr_err",  32'(rxErr),  0);
    chk("mr_out",  32'(rxOut),  0);
    idle(5);
    reset = 1'b1;
    idle(BIT * 2);
    chk("mr_pulses", 32'((doneCnt - d0) + (errCnt - e0)), 0);

    // line already low at reset release is not a start edge
    rxIn = 1'b0; reset = 1'b0;
    idle(3);
    reset = 1'b1;
    b0 = busyCyc;
    idle(BIT * 3);
    chk("low_rel_busy", 32'(busyCyc - b0), 0);
    rxIn = 1'b1;
    idle(BIT);
    sendFrame(8'h81, 1'b1, BIT);
    idle(BIT);
    chk("mr_81_done", 32'(doneCnt - d0), 1);
    chk("mr_81_out",  32'(rxOut), 'h81);
    chk("mr_81_err",  32'(errCnt - e0), 0);

    // enable dropped during bit 3, then back-to-back frames
    d0 = doneCnt; e0 = errCnt;
    sendBits(8'hC3, 2, BIT);
    @(negedge clk); rxIn = 1'b0;
    idle(BIT / 2);
    rxEn = 1'b0;
    @(negedge clk);
    chk("en_busy", 32'(rxBusy), 0);
    rxIn = 1'b1;
    idle(BIT * 2);
    chk("en_pulses", 32'((doneCnt - d0) + (errCnt - e0)), 0);
    chk("en_keep",   32'(rxOut), 'h81);
    rxEn = 1'b1;
    idle(10);
    q0 = gotQ.size();
    sendFrame(8'h00, 1'b1, BIT);
    sendFrame(8'hFF, 1'b1, BIT);
    idle(BIT);
    chk("b2b_done", 32'(doneCnt - d0), 2);
    if (gotQ.size() >= q0 + 2) begin
      chk("b2b_0", 32'(gotQ[q0]),     'h00);
      chk("b2b_1", 32'(gotQ[q0 + 1]), 'hFF);
    end else begin
      chk("b2b_cnt", 32'(gotQ.size() - q0), 2);
    end

    // +/-2% baud error
    for (int k = 0; k < 2; k++) begin
      d0 = doneCnt; e0 = errCnt;
      bc = (k == 0) ? 125 : 131;
      sendFrame(8'h55, 1'b1, bc);
      idle(BIT);
      chk("skew_done", 32'(doneCnt - d0), 1);
      chk("skew_out",  32'(rxOut), 'h55);
      chk("skew_err",  32'(errCnt - e0), 0);
    end

    // random bytes, bit periods within +/-2%, random idle gaps
    for (int k = 0; k < 8; k++) begin
      q0 = gotQ.size(); e0 = errCnt;
      rb  = 8'($urandom_range(0, 255));
      bc  = $urandom_range(125, 131);
      gap = $urandom_range(0, 40);
      sendFrame(rb, 1'b1, bc);
      idle(gap);
      chk("rnd_cnt", 32'(gotQ.size() - q0), 1);
      if (gotQ.size() > q0) chk("rnd_byte", 32'(gotQ[$]), 32'(rb));
      chk("rnd_err", 32'(errCnt - e0), 0);
    end

    idle(BIT);
    chk("excl", 32'(bothCnt), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart8_rx16.md
UART8_RX16 -- requirements
Module: uart8_rx16

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port rxEn  input  1  receiver enable.
REQ-007 SHALL have port rxIn  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port rxBusy  output  1  frame in progress.
REQ-009 SHALL have port rxDone  output  1  one-cycle pulse: valid byte on rxOut.
REQ-010 SHALL have port rxErr  output  1  one-cycle pulse: framing error.
REQ-011 SHALL have port rxOut  output  8  last correctly received byte.

Function
REQ-012 SHALL pass rxIn through a 2-flop synchronizer initialised to 1; all decisions use the synchronized value.
REQ-013 SHALL generate a sample tick every DIV = round(CLOCK_RATE / (BAUD_RATE*OVERSAMPLE)) clocks, i.e. 78 at the defaults; the divider restarts at 0 on a detected start edge.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: with rxEn=1, a synchronized 1->0 transition -> START and rxBusy=1 on the next clock.
REQ-016 START: at tick 8, take the majority of the samples at ticks 7, 8 and 9; 0 -> DATA; 1 -> IDLE, rxBusy=0, no pulse (glitch reject).
REQ-017 DATA: sample 8 bits LSB first, each by a 7/8/9 majority, with one bit per 16 ticks; after bit 7 -> STOP.
REQ-018 STOP: majority 1 -> load rxOut, pulse rxDone for 1 clock, rxBusy=0, -> IDLE in the same clock.
REQ-019 STOP: majority 0 -> pulse rxErr for 1 clock, leave rxOut unchanged, -> BREAK with rxBusy held at 1.
REQ-020 BREAK: remain until the synchronized line has been 1 for 16 consecutive ticks, then -> IDLE, rxBusy=0.
REQ-021 rxDone and rxErr SHALL never be high in the same cycle.
REQ-022 rxEn=0 in any state -> IDLE on the next clock, rxBusy=0, no pulse, rxOut held; the partial byte is discarded.
REQ-023 SHALL accept a start edge in the clock immediately after the rxDone pulse (back-to-back frames).
REQ-024 rxDone latency from the start falling edge SHALL be 9.5 bit periods ± 1 tick plus 3 synchronizer/register clocks.

Reset
REQ-025 While reset=0, SHALL hold rxBusy=0, rxDone=0, rxErr=0, rxOut=8'h00, state IDLE, divider, tick and bit counters at 0, and synchronizer flops at 1.
REQ-026 Reset assertion SHALL take effect immediately and abort any frame, with no pulse generated.
REQ-027 Reception SHALL begin only on a falling edge seen after reset is released; a line already low at release is ignored until it returns high.

Structure
REQ-028 A shared package uart8_pkg SHALL hold the state enum, the OVERSAMPLE default, and the mid-sample indices 7/8/9.
REQ-029 The tick divider SHALL be the sub-module uart8_baud_tick, parameterised by CLOCK_RATE, BAUD_RATE and OVERSAMPLE, with a synchronous restart input.
REQ-030 The RTL SHALL target 150-300 lines with no latches and no combinational path from rxIn to any output.

Verification
REQ-031 Defaults, rxEn=1, 8'h45 sent at 1248 clk/bit -> rxOut=8'h45, one rxDone pulse about 11860 clocks after the start edge, rxErr=0.
REQ-032 A 200-clock low glitch on the idle line -> rxBusy high for no more than 8 ticks plus 3 clocks, no rxDone or rxErr, state IDLE.
REQ-033 8'hA5 sent with stop bit 0 -> one rxErr pulse, rxOut keeps its previous value, no rxDone; the next 8'h3C after 16 idle ticks is received correctly.
REQ-034 reset driven to 0 for 5 clocks during bit 4 of 8'hFF -> all outputs at reset values immediately; a following 8'h81 is received correctly.
REQ-035 rxEn dropped during bit 3 -> rxBusy=0 the next clock, no pulses; rxEn restored and 8'h00 then 8'hFF sent back-to-back -> two rxDone pulses with the matching bytes.
REQ-036 Frames at ±2% baud error for 8'h55 -> received correctly, no rxErr.
